// File: rtl/alpu_iqueue_pkg.sv
// Shared record type for the per-execution-unit instruction queue feeding the ALPU operand cache.
package alpu_iqueue_pkg;

  typedef struct packed {
    logic [5:0] opcode;
    logic       op0m;
    logic [7:0] op0;
    logic       op1m;
    logic [7:0] op1;
    logic [5:0] dst;
  } type_iqueue_entry;

endpackage

// File: rtl/alpu_iqueue_if.sv
// Dispatch / ALPU-cache handshake bundle around alpu_iqueue; slave is the queue side.
interface alpu_iqueue_if
  import alpu_iqueue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);

  logic                       disp_valid;
  type_iqueue_entry           disp_entry;
  logic                       disp_ready;
  type_iqueue_entry           ireq_curr_instr;
  logic                       ireq_valid;
  logic                       issue_ack;
  logic                       flush;
  logic [$clog2(DEPTH):0]     occupancy;
  logic                       stall_timeout;
  logic [7:0]                 stall_tag;

  modport slave (
    input  disp_valid, disp_entry, issue_ack, flush,
    output disp_ready, ireq_curr_instr, ireq_valid, occupancy, stall_timeout, stall_tag
  );

  modport master (
    output disp_valid, disp_entry, issue_ack, flush,
    input  disp_ready, ireq_curr_instr, ireq_valid, occupancy, stall_timeout, stall_tag
  );

endinterface

// File: rtl/alpu_iqueue.sv
// In-order instruction queue: circular buffer whose head is the ALPU cache request,
// with a stall watchdog that pulses once when the head waits too long.
module alpu_iqueue
  import alpu_iqueue_pkg::*;
#(
  parameter int unsigned eu_idx      = 0,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  alpu_iqueue_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    WD_LIM   = 8'(STALL_LIMIT);

  type_iqueue_entry mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic [7:0]       wd;
  logic [7:0]       wd_nxt;
  logic             stall_q;
  logic             push;
  logic             pop;

  // Ready depends only on the registered count, so issue_ack never reaches disp_ready.
  assign bus.disp_ready      = (cnt != FULL_CNT);
  assign bus.ireq_valid      = (cnt != '0);
  assign bus.ireq_curr_instr = bus.ireq_valid ? mem[rp] : '0;
  assign bus.occupancy       = cnt;
  assign bus.stall_timeout   = stall_q;
  assign bus.stall_tag       = stall_q ? 8'(eu_idx) : 8'h00;

  assign push = bus.disp_valid & bus.disp_ready;
  assign pop  = bus.issue_ack & bus.ireq_valid;

  always_comb begin
    wd_nxt = wd;
    if (bus.flush || pop || !bus.ireq_valid) begin
      wd_nxt = '0;
    end else if (wd != WD_LIM) begin
      wd_nxt = wd + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      wd      <= '0;
      stall_q <= 1'b0;
    end else if (bus.flush) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      wd      <= '0;
      stall_q <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
      wd      <= wd_nxt;
      // Pulse only on the transition into the limit; saturation keeps it from re-firing.
      stall_q <= (wd_nxt == WD_LIM) && (wd != WD_LIM);
    end
  end

  // Entry storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem[wp] <= bus.disp_entry;
    end
  end

endmodule

// File: tb/tb_alpu_iqueue.sv
// Bench for alpu_iqueue: vector table, directed corner sequences and randomized traffic
// checked against a queue-based reference model.
module tb_alpu_iqueue;
  import alpu_iqueue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 5;

  logic clk;
  logic reset_n;

  alpu_iqueue_if #(.DEPTH(DEPTH)) bus ();

  alpu_iqueue #(.eu_idx(3), .DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  type_iqueue_entry mq[$];
  int               age   = 0;
  bit               mpulse = 1'b0;
  type_iqueue_entry zero_e = '0;

  typedef struct {
    bit       v;
    bit       ack;
    bit       fl;
    logic [7:0] op0;
    int       exp_occ;
    bit       exp_valid;
    logic [7:0] exp_op0;
  } vec_t;

  function automatic type_iqueue_entry mk(input logic [7:0] op0);
    type_iqueue_entry e;
    e.opcode = 6'(op0 ^ 8'h15);
    e.op0m   = 1'b1;
    e.op0    = op0;
    e.op1m   = 1'b1;
    e.op1    = op0 + 8'h40;
    e.dst    = 6'(op0 + 8'd7);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic compare_all();
    type_iqueue_entry exp_head;
    exp_head = (mq.size() != 0) ? mq[0] : '0;
    chk("disp_ready",    64'(bus.disp_ready),      64'(mq.size() < DEPTH));
    chk("ireq_valid",    64'(bus.ireq_valid),      64'(mq.size() != 0));
    chk("head",          64'(bus.ireq_curr_instr), 64'(exp_head));
    chk("occupancy",     64'(bus.occupancy),       64'(mq.size()));
    chk("stall_timeout", 64'(bus.stall_timeout),   64'(mpulse));
    chk("stall_tag",     64'(bus.stall_tag),       mpulse ? 64'd3 : 64'd0);
  endtask

  // Reference behaviour for one clock edge, from the queue's rules.
  task automatic model_edge(input bit v, input type_iqueue_entry e, input bit ack, input bit fl);
    bit was_empty;
    bit can_push;
    bit did_pop;
    if (fl) begin
      mq.delete();
      age    = 0;
      mpulse = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      can_push  = (mq.size() < DEPTH);
      did_pop   = ack && !was_empty;
      if (did_pop) void'(mq.pop_front());
      if (v && can_push) mq.push_back(e);
      if (did_pop || was_empty) begin
        age    = 0;
        mpulse = 1'b0;
      end else begin
        mpulse = (age < LIMIT) && (age + 1 == LIMIT);
        age    = (age < LIMIT) ? age + 1 : LIMIT;
      end
    end
  endtask

  task automatic step(input bit v, input type_iqueue_entry e, input bit ack, input bit fl);
    bus.disp_valid = v;
    bus.disp_entry = e;
    bus.issue_ack  = ack;
    bus.flush      = fl;
    @(posedge clk);
    model_edge(v, e, ack, fl);
    #1;
    compare_all();
    bus.disp_valid = 1'b0;
    bus.issue_ack  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, zero_e, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && mq.size() != 0; k++) step(1'b0, zero_e, 1'b1, 1'b0);
    chk("drain_empty", 64'(bus.ireq_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(bus.disp_ready),      64'd1);
    chk({tag, "_valid"}, 64'(bus.ireq_valid),      64'd0);
    chk({tag, "_instr"}, 64'(bus.ireq_curr_instr), 64'd0);
    chk({tag, "_occ"},   64'(bus.occupancy),       64'd0);
    chk({tag, "_stall"}, 64'(bus.stall_timeout),   64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int pulses;
    int at;

    vecs[0] = '{1, 0, 0, 8'h01, 1, 1, 8'h01};
    vecs[1] = '{1, 0, 0, 8'h02, 2, 1, 8'h01};
    vecs[2] = '{1, 0, 0, 8'h03, 3, 1, 8'h01};
    vecs[3] = '{0, 1, 0, 8'h00, 2, 1, 8'h02};
    vecs[4] = '{0, 1, 0, 8'h00, 1, 1, 8'h03};
    vecs[5] = '{0, 1, 0, 8'h00, 0, 0, 8'h00};

    reset_n        = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_entry = '0;
    bus.issue_ack  = 1'b0;
    bus.flush      = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Table-driven: three pushes then three acks.
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].v, mk(vecs[i].op0), vecs[i].ack, vecs[i].fl);
      chk("vec_occ",   64'(bus.occupancy),      64'(vecs[i].exp_occ));
      chk("vec_valid", 64'(bus.ireq_valid),     64'(vecs[i].exp_valid));
      chk("vec_op0",   64'(bus.ireq_curr_instr.op0), 64'(vecs[i].exp_op0));
    end
    chk("empty_zero", 64'(bus.ireq_curr_instr), 64'd0);

    // Fill, refuse a fifth entry, then push+ack while full and again once partial.
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(8'(8'h10 + i)), 1'b0, 1'b0);
    chk("full_ready", 64'(bus.disp_ready), 64'd0);
    step(1'b1, mk(8'h99), 1'b0, 1'b0);
    chk("full_drop_occ", 64'(bus.occupancy), 64'd4);
    step(1'b1, mk(8'h9A), 1'b1, 1'b0);
    chk("full_pushack_occ", 64'(bus.occupancy), 64'd3);
    chk("full_pushack_head", 64'(bus.ireq_curr_instr.op0), 64'h11);
    step(1'b1, mk(8'h9B), 1'b1, 1'b0);
    chk("partial_pushack_occ", 64'(bus.occupancy), 64'd3);
    drain();

    // Streaming: one push and one pop every cycle.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, mk(8'(i)), (i != 0), 1'b0);
      chk("stream_head", 64'(bus.ireq_curr_instr.op0), 64'(i));
      chk("stream_occ",  64'(bus.occupancy), 64'd1);
    end
    step(1'b0, zero_e, 1'b1, 1'b0);
    chk("stream_end", 64'(bus.ireq_valid), 64'd0);

    // Watchdog: one pulse five cycles after the head appears, none afterwards.
    step(1'b1, mk(8'hA0), 1'b0, 1'b0);
    pulses = 0;
    at = -1;
    for (int k = 1; k <= 12; k++) begin
      idle();
      if (bus.stall_timeout) begin
        pulses++;
        at = k;
      end
    end
    chk("wd_pulses", 64'(pulses), 64'd1);
    chk("wd_cycle",  64'(at), 64'd5);
    step(1'b1, mk(8'hA1), 1'b0, 1'b0);
    step(1'b0, zero_e, 1'b1, 1'b0);
    chk("wd_newhead", 64'(bus.ireq_curr_instr.op0), 64'hA1);
    pulses = 0;
    at = -1;
    for (int k = 1; k <= 8; k++) begin
      idle();
      if (bus.stall_timeout) begin
        pulses++;
        at = k;
      end
    end
    chk("wd2_pulses", 64'(pulses), 64'd1);
    chk("wd2_cycle",  64'(at), 64'd5);
    drain();

    // Flush beats a same-cycle push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, mk(8'(8'h30 + i)), 1'b0, 1'b0);
    step(1'b1, mk(8'hAA), 1'b1, 1'b1);
    chk("flush_occ",   64'(bus.occupancy),  64'd0);
    chk("flush_valid", 64'(bus.ireq_valid), 64'd0);
    chk("flush_ready", 64'(bus.disp_ready), 64'd1);
    idle();
    chk("flush_push_lost", 64'(bus.occupancy), 64'd0);

    // Asynchronous reset between edges.
    step(1'b1, mk(8'h41), 1'b0, 1'b0);
    step(1'b1, mk(8'h42), 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    mq.delete();
    age    = 0;
    mpulse = 1'b0;
    #2 reset_n = 1'b1;
    step(1'b1, mk(8'h5A), 1'b0, 1'b0);
    chk("post_reset_head", 64'(bus.ireq_curr_instr.op0), 64'h5A);
    chk("post_reset_occ",  64'(bus.occupancy), 64'd1);
    drain();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 60), mk(8'($urandom)),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alpu_iqueue.md
# alpu_iqueue

Per-execution-unit in-order instruction queue sitting directly upstream of the ALPU operand cache. It accepts dispatched `type_iqueue_entry` records, buffers up to `DEPTH` of them, and presents the head entry as the cache's current-instruction request. The head is retired when the cache/ALPU side acknowledges it. A stall watchdog flags a head that is not retired within a bounded number of cycles.

## Interface
- `eu_idx`, 0, index of the owning execution unit; appears only in the `stall_timeout` debug tag.
- `DEPTH`, 4, entry count; power of two, 2..16.
- `STALL_LIMIT`, 64, cycles a valid head may wait unacknowledged before `stall_timeout` pulses; 1..255.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset_n`  in  1  reset; asynchronous assert, active low.
- `disp_valid`  in  1  dispatch offers an entry.
- `disp_entry`  in  `$bits(type_iqueue_entry)`  dispatched instruction.
- `disp_ready`  out  1  queue can accept this cycle.
- `ireq_curr_instr`  out  `$bits(type_iqueue_entry)`  head entry to the ALPU cache.
- `ireq_valid`  out  1  `ireq_curr_instr` holds a real entry.
- `issue_ack`  in  1  head consumed; pop.
- `flush`  in  1  discard all entries.
- `occupancy`  out  `$clog2(DEPTH)+1`  entries held.
- `stall_timeout`  out  1  one-cycle watchdog pulse.

## Operation
- Circular buffer of `DEPTH` entries with write pointer `wp`, read pointer `rp` and count `cnt`. Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- Push occurs when `disp_valid & disp_ready`; the entry is written at `wp`, then `wp++`.
- Pop occurs when `issue_ack & ireq_valid`, then `rp++`. An `issue_ack` while `ireq_valid=0` is ignored.
- `disp_ready = (cnt != DEPTH)`. It is registered-state-derived only and has no combinational path from `issue_ack`.
- Simultaneous push and pop: both happen and `cnt` is unchanged. When full, no push is possible that cycle, even if a pop occurs.
- `ireq_valid = (cnt != 0)`.
- When `ireq_valid=1`, `ireq_curr_instr` is the entry at `rp`. When `ireq_valid=0`, it is driven all-zero, so `op0m=op1m=0` and the cache issues no operand reads.
- `flush` clears `wp`, `rp`, `cnt` and the watchdog in the cycle it is sampled. It has priority over a same-cycle push or pop, and that push is dropped.
- Watchdog: an 8-bit counter `wd`.
  - Clears on pop, on flush, or when `ireq_valid=0`.
  - Otherwise increments, saturating at `STALL_LIMIT`.
  - `stall_timeout` pulses high for exactly one cycle, in the cycle `wd` transitions to `STALL_LIMIT`. It does not re-pulse until `wd` has cleared.
- `occupancy = cnt`.
- States (derived, not a separate FSM):
  - EMPTY (`cnt=0`)
  - PARTIAL
  - FULL (`cnt=DEPTH`)
  - EMPTY→PARTIAL on push. PARTIAL→FULL on push without pop. FULL→PARTIAL on pop. PARTIAL→EMPTY on a pop of the last entry. Any state→EMPTY on flush.

## Timing
- Reset (asynchronous): `cnt=0`, `wp=rp=0`, `wd=0`.
- Outputs during reset: `disp_ready=1`, `ireq_valid=0`, `ireq_curr_instr=0`, `occupancy=0`, `stall_timeout=0`.
- Reset asserted mid-operation discards all entries immediately, with no wait for a clock edge.
- Push-to-head latency is 1 cycle. An entry pushed at edge N is visible on `ireq_curr_instr` after edge N, with no same-cycle bypass.
- Pop-to-next-head latency is 1 cycle. After edge N with a pop, `ireq_curr_instr` shows the next entry, or zero if the queue is now empty.
- Back-to-back operation sustains one push and one pop per cycle indefinitely.
- Head contents are stable while `ireq_valid=1` and no pop occurs.
- Flush takes effect at the sampling edge. After that edge: `ireq_valid=0` and `disp_ready=1`.

## Test plan
- Reset then push three entries with `op0` addresses 0x1, 0x2, 0x3, no ack. Required: `occupancy`=3, head op0=0x1. Then ack for three cycles: heads 0x2 and 0x3 appear in turn, then `ireq_valid=0` with all-zero output.
- Fill to `DEPTH=4`. Required: `disp_ready=0`, and a fifth `disp_valid` is dropped. Then push and ack in the same cycle: the push is still refused and `occupancy`=3. On the next cycle push and ack together: `occupancy` stays 3.
- Stream 20 entries with `disp_valid` and `issue_ack` both held high. Required: pointers wrap at least 4 times, heads appear in order 0..19 with no loss or duplication, and `occupancy` is never above 1.
- Hold the head with no ack, `STALL_LIMIT`=5. Required: `stall_timeout` pulses once, 5 cycles after the head becomes valid, and stays low thereafter. Then ack: `wd` clears, and a new head pulses again 5 cycles later.
- With `occupancy`=3, assert `flush` together with `disp_valid` and `issue_ack`. Required: after the edge `occupancy`=0, `ireq_valid=0`, and the flushed-cycle push is lost.
- With `occupancy`=2, assert `reset_n` low between clock edges. Required: outputs go to reset values immediately, and after release the queue accepts a fresh entry normally.
